// File: rtl/reg_write_back.sv
// -----------------------------------------------------------------------------
// reg_write_back
//
// Write side of the architectural register file. Write-back requests from the
// execute stage arrive through a valid/ready handshake. They are buffered in a
// small in-order queue, and the queue commits at most one entry per cycle into
// the register array. A pending-write mask lets decode stall reads of registers
// that still have writes in flight.
//
// Optional build macro: REG_WB_FORWARD_EN
//   defined     -> read ports forward the youngest queued write to the address
//   not defined -> read ports return committed array contents only
// The pending mask behaves the same in both builds.
// -----------------------------------------------------------------------------
module reg_write_back #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     commit_stall,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    output logic [DATA_W-1:0]        read1,
    output logic [DATA_W-1:0]        read2,
    output logic [NUM_REGS-1:0]      pending,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     commit_valid,
    output logic [ADDR_W-1:0]        commit_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // Pointers carry one extra wrap bit so that full and empty can be
    // told apart when the index bits are equal.
    logic [PTR_W:0]        head_reg;
    logic [PTR_W:0]        tail_reg;

    // ready_en_reg keeps wb_ready low until the first edge after reset
    // deasserts, so the producer never sees a ready that reset could still
    // cancel.
    logic                  ready_en_reg;

    logic                  commit_valid_reg;
    logic [ADDR_W-1:0]     commit_rd_reg;

    // The queue payload is only meaningful inside the [head, tail) window,
    // so it needs no reset.
    logic [ADDR_W-1:0]     q_rd   [DEPTH];
    logic [DATA_W-1:0]     q_data [DEPTH];

    // The architectural array. It is cleared asynchronously, so it is kept
    // in flops rather than block RAM.
    logic [DATA_W-1:0]     regs   [NUM_REGS];

    // ------------------------------------------------------------------------
    // Queue status and handshake
    // ------------------------------------------------------------------------
    logic [PTR_W:0]        count;
    logic [PTR_W-1:0]      head_idx;
    logic [PTR_W-1:0]      tail_idx;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  enq;
    logic                  deq;
    logic [ADDR_W-1:0]     head_rd;
    logic [DATA_W-1:0]     head_data;
    logic [DEPTH-1:0]      entry_valid;

    assign count     = tail_reg - head_reg;
    assign head_idx  = head_reg[PTR_W-1:0];
    assign tail_idx  = tail_reg[PTR_W-1:0];
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);

    // Ready never looks at wb_valid. While the queue is full, ready stays
    // low even if a commit frees a slot on the same edge.
    assign wb_ready  = ready_en_reg && !full && !rst;

    // A write to r0 completes the handshake but is dropped. r0 is hardwired
    // to zero, so queueing the write would only produce a false pending bit.
    assign accept    = wb_valid && wb_ready;
    assign enq       = accept && (wb_rd != '0);

    // Commit looks only at the registered pointers. An entry accepted on this
    // edge therefore cannot commit before the following edge.
    assign deq       = !empty && !commit_stall;

    assign head_rd   = q_rd[head_idx];
    assign head_data = q_data[head_idx];

    assign occupancy    = count;
    assign commit_valid = commit_valid_reg;
    assign commit_rd    = commit_rd_reg;

    // ------------------------------------------------------------------------
    // Per-entry liveness: an entry is live when its distance from head,
    // taken modulo DEPTH, is less than the current count.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - head_idx;
            assign entry_valid[gi] = ({1'b0, offset} < count);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------------

    // Enable ready one edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    // Advance the head and tail pointers. The extra wrap bit lets them
    // roll over naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (enq) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (deq) begin
                head_reg <= head_reg + 1'b1;
            end
        end
    end

    // Store an accepted request at the tail slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[tail_idx]   <= wb_rd;
            q_data[tail_idx] <= wb_data;
        end
    end

    // Register the commit strobe so that it is a clean one-cycle pulse
    // following the commit edge. commit_rd holds its last value otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_valid_reg <= 1'b0;
            commit_rd_reg    <= '0;
        end else begin
            commit_valid_reg <= deq;
            if (deq) begin
                commit_rd_reg <= head_rd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Architectural array: each register has its own write decode. r0 is a
    // constant zero.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_flop
                // Take the head entry's data when it commits to this register.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        regs[gi] <= '0;
                    end else if (deq && (head_rd == ADDR_W'(gi))) begin
                        regs[gi] <= head_data;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Pending mask: OR together a one-hot decode of every live entry's rd.
    // A register with several queued writes stays flagged until the last
    // of those writes commits.
    // ------------------------------------------------------------------------
    // Build the mask from the live queue window.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending[q_rd[i]] = 1'b1;
            end
        end
        // r0 is never queued. Clearing it here keeps the bit tied off
        // regardless of whatever stale payload a dead slot holds.
        pending[0] = 1'b0;
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        logic [PTR_W-1:0]  idx;
        value = regs[addr];
        idx   = '0;
`ifdef REG_WB_FORWARD_EN
        // Scan from oldest to youngest. The last match wins, so the youngest
        // queued write to this address overrides both older entries and the
        // array.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_idx + PTR_W'(k);
            if (((PTR_W+1)'(k) < count) && (q_rd[idx] == addr)) begin
                value = q_data[idx];
            end
        end
`else
        // Reads see committed state only. The scan index is unused in this
        // build.
        idx = idx;
`endif
        if (addr == '0) begin
            value = '0;
        end
        return value;
    endfunction

    // Read port 1: combinational lookup.
    always_comb begin
        read1 = lookup(rs);
    end

    // Read port 2: combinational lookup.
    always_comb begin
        read2 = lookup(rt);
    end

endmodule

// File: tb/tb_reg_write_back.sv
// -----------------------------------------------------------------------------
// tb_reg_write_back: directed self-checking bench for reg_write_back.
// Expected read values change when REG_WB_FORWARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_reg_write_back;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int DEPTH    = 4;

`ifdef REG_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [ADDR_W-1:0]      wb_rd;
    logic [DATA_W-1:0]      wb_data;
    logic                   commit_stall;
    logic [ADDR_W-1:0]      rs;
    logic [ADDR_W-1:0]      rt;
    logic [DATA_W-1:0]      read1;
    logic [DATA_W-1:0]      read2;
    logic [NUM_REGS-1:0]    pending;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   commit_valid;
    logic [ADDR_W-1:0]      commit_rd;

    int errors = 0;
    int checks = 0;

    reg_write_back #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .commit_stall(commit_stall),
        .rs          (rs),
        .rt          (rt),
        .read1       (read1),
        .read2       (read2),
        .pending     (pending),
        .occupancy   (occupancy),
        .commit_valid(commit_valid),
        .commit_rd   (commit_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance one edge; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        commit_stall = 1'b0; rs = '0; rt = '0;
        repeat (3) tick();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wb_ready); end
        checks++; if (commit_valid !== 1'b0 || commit_rd !== 5'd0) begin errors++; $display("FAIL reset_commit: got v=%b rd=%0d want 0/0", commit_valid, commit_rd); end
        rst = 1'b0;
        tick();
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", wb_ready); end
        $display("reset released, wb_ready=%b", wb_ready);
    endtask

    task automatic test_single_write();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF; rs = 5'd3;
        tick();
        wb_valid = 1'b0;
        $display("enqueue r3=%h", 32'hDEADBEEF);
        checks++; if (pending[3] !== 1'b1 || occupancy !== 3'd1) begin errors++; $display("FAIL single_pending: got p3=%b occ=%0d want 1/1", pending[3], occupancy); end
        checks++; if (read1 !== (FWD ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL single_read_queued: got %h want %h", read1, FWD ? 32'hDEADBEEF : 32'h0); end
        tick();
        checks++; if (commit_valid !== 1'b1 || commit_rd !== 5'd3) begin errors++; $display("FAIL single_commit: got v=%b rd=%0d want 1/3", commit_valid, commit_rd); end
        checks++; if (read1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_read: got %h want deadbeef", read1); end
        checks++; if (occupancy !== 3'd0 || pending !== 32'h0) begin errors++; $display("FAIL single_drain: got occ=%0d p=%h want 0/0", occupancy, pending); end
        tick();
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", commit_valid); end
    endtask

    task automatic test_fill();
        logic [4:0] exp_rd  [5];
        logic [2:0] exp_occ [5];
        exp_rd  = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
        exp_occ = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        commit_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'h100 + 32'(i);
            checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, wb_ready); end
            tick();
            $display("enqueue r%0d=%h", i, wb_data);
        end
        wb_rd = 5'd9; wb_data = 32'h900;
        checks++; if (occupancy !== 3'd4 || wb_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got occ=%0d rdy=%b want 4/0", occupancy, wb_ready); end
        tick();
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_held: got occ=%0d want 4", occupancy); end
        commit_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            $display("commit r%0d occ=%0d", commit_rd, occupancy);
            checks++; if (commit_valid !== 1'b1 || commit_rd !== exp_rd[k]) begin errors++; $display("FAIL fill_order_%0d: got v=%b rd=%0d want 1/%0d", k, commit_valid, commit_rd, exp_rd[k]); end
            checks++; if (occupancy !== exp_occ[k]) begin errors++; $display("FAIL fill_occ_%0d: got %0d want %0d", k, occupancy, exp_occ[k]); end
            if (k == 0) begin
                checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_back: got %b want 1", wb_ready); end
            end
            if (k == 1) wb_valid = 1'b0;
        end
        rs = 5'd4; rt = 5'd9;
        #1;
        checks++; if (read1 !== 32'h104 || read2 !== 32'h900) begin errors++; $display("FAIL fill_reads: got %h/%h want 104/900", read1, read2); end
    endtask

    task automatic test_same_reg();
        commit_stall = 1'b1; rs = 5'd5; rt = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h11;
        tick();
        wb_data = 32'h22;
        tick();
        wb_valid = 1'b0;
        $display("enqueue r5=11, r5=22");
        checks++; if (pending[5] !== 1'b1 || occupancy !== 3'd2) begin errors++; $display("FAIL same_pending: got p5=%b occ=%0d want 1/2", pending[5], occupancy); end
        checks++; if (read1 !== (FWD ? 32'h22 : 32'h0)) begin errors++; $display("FAIL same_read_queued: got %h want %h", read1, FWD ? 32'h22 : 32'h0); end
        commit_stall = 1'b0;
        tick();
        checks++; if (pending[5] !== 1'b1 || commit_rd !== 5'd5) begin errors++; $display("FAIL same_first: got p5=%b rd=%0d want 1/5", pending[5], commit_rd); end
        checks++; if (read2 !== (FWD ? 32'h22 : 32'h11)) begin errors++; $display("FAIL same_mid_read: got %h want %h", read2, FWD ? 32'h22 : 32'h11); end
        tick();
        checks++; if (pending[5] !== 1'b0 || read2 !== 32'h22) begin errors++; $display("FAIL same_final: got p5=%b rd2=%h want 0/22", pending[5], read2); end
    endtask

    task automatic test_reg_zero();
        rs = 5'd0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL r0_ready: got %b want 1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        $display("handshake r0=ffffffff");
        checks++; if (occupancy !== 3'd0 || pending !== 32'h0) begin errors++; $display("FAIL r0_queue: got occ=%0d p=%h want 0/0", occupancy, pending); end
        tick();
        checks++; if (read1 !== 32'h0 || commit_valid !== 1'b0) begin errors++; $display("FAIL r0_read: got %h v=%b want 0/0", read1, commit_valid); end
    endtask

    task automatic test_mid_reset();
        commit_stall = 1'b1;
        for (int i = 10; i < 13; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i); wb_data = 32'hA000 + 32'(i);
            tick();
        end
        wb_valid = 1'b0;
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL mid_occ_before: got %0d want 3", occupancy); end
        commit_stall = 1'b0;
        rst = 1'b1;
        #1;
        $display("async reset with 3 queued");
        checks++; if (occupancy !== 3'd0 || pending !== 32'h0 || wb_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got occ=%0d p=%h rdy=%b want 0/0/0", occupancy, pending, wb_ready); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL mid_no_commit_%0d: got %b want 0", k, commit_valid); end
        end
        rs = 5'd4; rt = 5'd5;
        #1;
        checks++; if (read1 !== 32'h0 || read2 !== 32'h0) begin errors++; $display("FAIL mid_reads: got %h/%h want 0/0", read1, read2); end
        rs = 5'd9; rt = 5'd3;
        #1;
        checks++; if (read1 !== 32'h0 || read2 !== 32'h0) begin errors++; $display("FAIL mid_reads2: got %h/%h want 0/0", read1, read2); end
    endtask

    task automatic test_forward();
        commit_stall = 1'b1; rs = 5'd7;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        tick();
        wb_data = 32'hBB;
        tick();
        wb_valid = 1'b0;
        $display("enqueue r7=aa, r7=bb");
        checks++; if (read1 !== (FWD ? 32'hBB : 32'h0)) begin errors++; $display("FAIL fwd_queued: got %h want %h", read1, FWD ? 32'hBB : 32'h0); end
        commit_stall = 1'b0;
        tick();
        checks++; if (read1 !== (FWD ? 32'hBB : 32'hAA)) begin errors++; $display("FAIL fwd_mid: got %h want %h", read1, FWD ? 32'hBB : 32'hAA); end
        tick();
        checks++; if (read1 !== 32'hBB || pending[7] !== 1'b0) begin errors++; $display("FAIL fwd_final: got %h p7=%b want bb/0", read1, pending[7]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill();
        test_same_reg();
        test_reg_zero();
        test_mid_reset();
        test_forward();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_back.md
Name: reg_write_back

Overview:
Write side of the 32-entry register file. It accepts write-back requests (destination register plus 32-bit data) from the execute stage through a valid/ready handshake and buffers them in an in-order queue. It commits at most one entry per cycle into the architectural register array. It also exports a pending-write mask, so the decode stage can stall reads of registers that still have queued writes.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NUM_REGS, 32, register count (2**ADDR_W)
DEPTH, 4, write queue entries; power of 2, >=2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
wb_valid  in  1  write-back request valid
wb_ready  out  1  queue can accept a request
wb_rd  in  ADDR_W  destination register
wb_data  in  DATA_W  write data
commit_stall  in  1  inhibits commit for this cycle
rs  in  ADDR_W  read port 1 address
rt  in  ADDR_W  read port 2 address
read1  out  DATA_W  read port 1 data (combinational)
read2  out  DATA_W  read port 2 data (combinational)
pending  out  NUM_REGS  bit i = 1 when a queued write targets register i
occupancy  out  $clog2(DEPTH)+1  number of queued entries
commit_valid  out  1  pulse: an entry was committed this cycle
commit_rd  out  ADDR_W  register committed (valid with commit_valid)

Behaviour:
- Reset is asynchronous, active-high. While rst is high: all array entries = 0, queue empty, occupancy = 0, pending = 0, commit_valid = 0, commit_rd = 0, wb_ready = 0. On the first clk edge after rst deasserts, wb_ready = 1.
- A reset asserted mid-operation discards all queued entries, and none of them commit.
- Handshake:
  - Transfer occurs on a clk edge where wb_valid && wb_ready.
  - wb_ready = !full && !rst.
  - wb_ready does not depend on wb_valid.
  - When full, wb_ready = 0 even if a commit happens the same cycle (no full-bypass).
- Register 0:
  - A request with wb_rd = 0 is accepted (handshake completes) but not enqueued, and pending[0] never sets.
  - read1/read2 always return 0 for address 0.
- Enqueue: the entry is written at the tail pointer, and the tail increments modulo DEPTH.
- Commit:
  - Condition: queue not empty && !commit_stall.
  - On the edge, the head entry writes array[rd] and the head pointer increments modulo DEPTH.
  - commit_valid and commit_rd are registered: high for exactly one cycle following the commit edge.
  - Commits are strictly in enqueue order.
- Simultaneous enqueue and commit (queue not full): both happen and occupancy is unchanged.
  - Same cycle with the queue empty: the new entry does not commit that cycle. Minimum enqueue-to-commit latency is 1 cycle, i.e. commit on the edge after the accepting edge.
- Occupancy is DEPTH when full and 0 when empty. Pointers carry an extra wrap bit to distinguish the two.
- pending:
  - Derived combinationally from the valid queue entries.
  - A register with several queued writes stays set until its last queued write commits.
- Reads: without the optional feature, read1/read2 return committed array contents only. A commit becomes visible on the cycle after its commit edge.

Optional Feature:
FORWARD_EN_ macro: REG_WB_FORWARD_EN
- Defined: read1/read2 return the data of the youngest queued entry whose rd matches the address. If no entry matches, they return array contents. Address 0 still returns 0.
- Not defined: reads see committed state only, per Behaviour.
- pending is identical in both builds.

Test Plan:
- Reset then single write: wb_rd=3, wb_data=0xDEADBEEF, one valid cycle. Next cycle pending[3]=1 and occupancy=1. One cycle later commit_valid=1, commit_rd=3, and read1 with rs=3 = 0xDEADBEEF.
- Fill with commit_stall=1: 4 writes to regs 1..4. Then occupancy=4, wb_ready=0, and a 5th request is held. Release stall: commits occur in order 1,2,3,4 on consecutive cycles, and wb_ready returns to 1 after the first commit.
- Same-register ordering: writes r5=0x11 then r5=0x22 with stall. pending[5] stays 1 until the second commit, and the final read2 with rt=5 = 0x22.
- Register 0: write r0=0xFFFFFFFF. Handshake completes, occupancy stays 0, pending=0, and read1 with rs=0 = 0.
- Reset mid-operation: 3 entries queued with stall, then rst pulses. occupancy=0, pending=0, no commit_valid afterwards, and all reads = 0.
- REG_WB_FORWARD_EN defined: queue r7=0xAA, then r7=0xBB, with stall. rs=7 gives read1=0xBB before any commit. Without the macro, read1=0 until the commits complete.
